// File: rtl/l0_pool.sv
// Layer-0 2x2 max-pool reader: scans the 26x26 feature-map RAM window by window
// and streams one signed maximum per window to the next layer's buffer.
module l0_pool #(
  parameter int IN_DIM = 26,
  parameter int DW     = 18,
  parameter int AW     = 10,
  parameter int OW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] addr_rd,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [OW-1:0] out_addr,
  output logic          busy,
  output logic          done
);

  localparam int H  = IN_DIM / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t               state, state_n;
  logic [1:0]           e_q, e_n;
  logic [CW-1:0]        c_q, c_n, r_q, r_n;
  logic [AW-1:0]        row_base, rb_n, col_off, co_n, off_n, addr_n;
  logic                 drain_cnt;
  logic                 last_rd;
  logic                 rd_vld;
  logic [1:0]           rd_e;
  logic signed [DW-1:0] acc, acc_n;
  logic [OW-1:0]        wcnt;
  logic                 emit;

  assign last_rd = (e_q == 2'd3) && (c_q == CW'(H - 1)) && (r_q == CW'(H - 1));
  assign busy    = (state != IDLE);
  assign done    = (state == FIN);
  assign emit    = rd_vld && (rd_e == 2'd3);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = ISSUE;
      ISSUE:   if (last_rd) state_n = DRAIN;
      DRAIN:   if (drain_cnt) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Address = row base + 2*col + element offset, all tracked incrementally.
  always_comb begin
    e_n  = e_q + 2'd1;
    c_n  = c_q;
    r_n  = r_q;
    rb_n = row_base;
    co_n = col_off;
    if (e_q == 2'd3) begin
      if (c_q == CW'(H - 1)) begin
        c_n  = '0;
        co_n = '0;
        r_n  = r_q + CW'(1);
        rb_n = row_base + AW'(2 * IN_DIM);
      end else begin
        c_n  = c_q + CW'(1);
        co_n = col_off + AW'(2);
      end
    end
    case (e_n)
      2'd0:    off_n = '0;
      2'd1:    off_n = AW'(1);
      2'd2:    off_n = AW'(IN_DIM);
      default: off_n = AW'(IN_DIM + 1);
    endcase
    addr_n = rb_n + co_n + off_n;
  end

  // Element 0 reloads; later elements keep the existing value on a tie.
  always_comb begin
    acc_n = acc;
    if (rd_e == 2'd0)
      acc_n = $signed(rd_data);
    else if ($signed(rd_data) > acc)
      acc_n = $signed(rd_data);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      e_q       <= '0;
      c_q       <= '0;
      r_q       <= '0;
      row_base  <= '0;
      col_off   <= '0;
      addr_rd   <= '0;
      drain_cnt <= 1'b0;
      rd_vld    <= 1'b0;
      rd_e      <= '0;
      acc       <= '0;
      wcnt      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= (state == DRAIN) && !drain_cnt;
      if (state == IDLE && start) begin
        e_q      <= '0;
        c_q      <= '0;
        r_q      <= '0;
        row_base <= '0;
        col_off  <= '0;
        addr_rd  <= '0;
        wcnt     <= '0;
      end else if (state == ISSUE && !last_rd) begin
        e_q      <= e_n;
        c_q      <= c_n;
        r_q      <= r_n;
        row_base <= rb_n;
        col_off  <= co_n;
        addr_rd  <= addr_n;
      end
      rd_vld    <= (state == ISSUE);
      rd_e      <= e_q;
      if (rd_vld) acc <= acc_n;
      out_valid <= emit;
      if (emit) begin
        out_data <= acc_n;
        out_addr <= wcnt;
        wcnt     <= wcnt + OW'(1);
      end
    end
  end

endmodule
